// File: rtl/time_entry_pkg.sv
// Shared types, key codes and the BCD time range check for the keypad time-entry front end.
package time_entry_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 3;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR      = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_LOAD_TIME  = 4'hB;
  localparam logic [DIGIT_W-1:0] KEY_LOAD_ALARM = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] ms_hr;
    logic [DIGIT_W-1:0] ls_hr;
    logic [DIGIT_W-1:0] ms_min;
    logic [DIGIT_W-1:0] ls_min;
  } bcd_time_t;

  // True when the four digits form a legal 24-hour HH:MM value.
  function automatic logic bcd_time_valid(input logic [DIGIT_W-1:0] ms_hr,
                                          input logic [DIGIT_W-1:0] ls_hr,
                                          input logic [DIGIT_W-1:0] ms_min,
                                          input logic [DIGIT_W-1:0] ls_min);
    logic hr_ok;
    hr_ok = (ms_hr < 4'd2) ? (ls_hr <= 4'd9) :
            (ms_hr == 4'd2) ? (ls_hr <= 4'd3) : 1'b0;
    return hr_ok && (ms_min <= 4'd5) && (ls_min <= 4'd9);
  endfunction

endpackage

// File: rtl/time_entry_keypad_if.sv
// Load bus from the keypad entry (writer) to the time counter / alarm register (reader).
interface time_entry_keypad_if;
  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_min;
  logic       load_new_c;
  logic       load_new_a;

  modport master (
    output new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min,
           load_new_c, load_new_a
  );

  modport slave (
    input  new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min,
           load_new_c, load_new_a
  );
endinterface

// File: rtl/entry_timeout_timer.sv
// Counts one-second ticks since the last key; flags abandonment of a stale entry.
module entry_timeout_timer #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  input  logic tick_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;

  // A clear in the same cycle as the final tick wins, so a key always suppresses the timeout.
  assign expired_c = enable_i & tick_i & ~clear_i & (cnt_q == CNT_W'(TIMEOUT_SEC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i || expired_c) begin
      cnt_q <= '0;
    end else if (enable_i && tick_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/time_entry_keypad.sv
// Keypad HH:MM entry buffer, range check and load-strobe generator for the alarm clock.
// Define TIME_ENTRY_RANGE_CHECK_EN to reject out-of-range times before committing.
module time_entry_keypad
  import time_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     one_second,
  input  logic                     key_valid,
  input  logic [DIGIT_W-1:0]       key_code,
  output logic [DIGIT_W-1:0]       key_ms_hr,
  output logic [DIGIT_W-1:0]       key_ls_hr,
  output logic [DIGIT_W-1:0]       key_ms_min,
  output logic [DIGIT_W-1:0]       key_ls_min,
  output logic                     entry_active,
  output logic                     entry_error,
  time_entry_keypad_if.master      load_if
);

  state_e             state_q;
  bcd_time_t          entry_q;
  bcd_time_t          new_q;
  logic [CNT_W-1:0]   digit_cnt_q;
  logic               load_c_q;
  logic               load_a_q;
  logic               active_q;
  logic               error_q;

  logic               key_is_digit;
  logic               key_is_load;
  logic               range_ok;
  logic               commit_ok;
  logic               timeout;
  bcd_time_t          entry_shift;

  assign key_is_digit = (key_code <= 4'd9);
  assign key_is_load  = (key_code == KEY_LOAD_TIME) || (key_code == KEY_LOAD_ALARM);
  assign entry_shift  = {entry_q.ls_hr, entry_q.ms_min, entry_q.ls_min, key_code};

`ifdef TIME_ENTRY_RANGE_CHECK_EN
  assign range_ok = bcd_time_valid(entry_q.ms_hr, entry_q.ls_hr, entry_q.ms_min, entry_q.ls_min);
`else
  assign range_ok = 1'b1;
`endif

  assign commit_ok = (digit_cnt_q == CNT_W'(4)) && range_ok;

  entry_timeout_timer #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (key_valid || (state_q == ST_IDLE)),
    .enable_i  (state_q != ST_IDLE),
    .tick_i    (one_second),
    .expired_c (timeout)
  );

  // Entry FSM; strobes default low so each commit pulses for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      new_q       <= '0;
      digit_cnt_q <= '0;
      load_c_q    <= 1'b0;
      load_a_q    <= 1'b0;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      load_c_q <= 1'b0;
      load_a_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (key_valid && key_is_digit) begin
            entry_q     <= entry_shift;
            digit_cnt_q <= CNT_W'(1);
            state_q     <= ST_ENTRY;
            active_q    <= 1'b1;
          end else if (key_valid && key_is_load) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end
        end
        ST_ENTRY: begin
          if (key_valid && key_is_digit) begin
            entry_q <= entry_shift;
            if (digit_cnt_q != CNT_W'(4)) digit_cnt_q <= digit_cnt_q + CNT_W'(1);
          end else if (key_valid && key_is_load && commit_ok) begin
            new_q       <= entry_q;
            load_c_q    <= (key_code == KEY_LOAD_TIME);
            load_a_q    <= (key_code == KEY_LOAD_ALARM);
            entry_q     <= '0;
            digit_cnt_q <= '0;
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
          end else if (key_valid && key_is_load) begin
            state_q  <= ST_ERROR;
            active_q <= 1'b0;
            error_q  <= 1'b1;
          end else if ((key_valid && key_code == KEY_CLEAR) || (!key_valid && timeout)) begin
            entry_q     <= '0;
            digit_cnt_q <= '0;
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
          end
        end
        ST_ERROR: begin
          if ((key_valid && key_code == KEY_CLEAR) || (!key_valid && timeout)) begin
            entry_q     <= '0;
            digit_cnt_q <= '0;
            state_q     <= ST_IDLE;
            error_q     <= 1'b0;
          end
        end
        default: begin
          entry_q     <= '0;
          digit_cnt_q <= '0;
          state_q     <= ST_IDLE;
          active_q    <= 1'b0;
          error_q     <= 1'b0;
        end
      endcase
    end
  end

  assign key_ms_hr    = entry_q.ms_hr;
  assign key_ls_hr    = entry_q.ls_hr;
  assign key_ms_min   = entry_q.ms_min;
  assign key_ls_min   = entry_q.ls_min;
  assign entry_active = active_q;
  assign entry_error  = error_q;

  assign load_if.new_current_time_ms_hr  = new_q.ms_hr;
  assign load_if.new_current_time_ls_hr  = new_q.ls_hr;
  assign load_if.new_current_time_ms_min = new_q.ms_min;
  assign load_if.new_current_time_ls_min = new_q.ls_min;
  assign load_if.load_new_c              = load_c_q;
  assign load_if.load_new_a              = load_a_q;

endmodule

// File: tb/tb_time_entry_keypad.sv
// Self-checking bench for time_entry_keypad: directed vector table, corner sequences and random vs. model.
module tb_time_entry_keypad;

  localparam int TMO = 10;

  logic       clk;
  logic       reset;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       entry_active, entry_error;

  time_entry_keypad_if lif ();

  time_entry_keypad #(.TIMEOUT_SEC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ms_hr    (key_ms_hr),
    .key_ls_hr    (key_ls_hr),
    .key_ms_min   (key_ms_min),
    .key_ls_min   (key_ls_min),
    .entry_active (entry_active),
    .entry_error  (entry_error),
    .load_if      (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model: digits kept as a list, times as numbers ----------------
  int          m_mode;      // 0 idle, 1 entry, 2 error
  int          m_dig[$];
  int          m_secs;
  logic [15:0] m_new;
  logic        m_lc, m_la;

  function automatic logic [15:0] m_disp();
    logic [15:0] d;
    d = 16'h0;
    foreach (m_dig[i]) d = (d << 4) | 16'(m_dig[i]);
    return d;
  endfunction

  function automatic bit m_time_ok();
`ifdef TIME_ENTRY_RANGE_CHECK_EN
    int hh, mm;
    hh = m_dig[0] * 10 + m_dig[1];
    mm = m_dig[2] * 10 + m_dig[3];
    return (hh <= 23) && (mm <= 59);
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_go_idle();
    m_dig.delete();
    m_mode = 0;
    m_secs = 0;
  endtask

  task automatic m_reset();
    m_go_idle();
    m_new = 16'h0;
    m_lc  = 1'b0;
    m_la  = 1'b0;
  endtask

  task automatic m_step(input logic kv, input logic [3:0] kc, input logic os);
    int k;
    k    = int'(kc);
    m_lc = 1'b0;
    m_la = 1'b0;
    if (kv) begin
      m_secs = 0;
      if (k <= 9) begin
        if (m_mode != 2) begin
          m_dig.push_back(k);
          if (m_dig.size() > 4) void'(m_dig.pop_front());
          m_mode = 1;
        end
      end else if (k == 10) begin
        if (m_mode != 0) m_go_idle();
      end else if (k == 11 || k == 12) begin
        if (m_mode == 1 && m_dig.size() == 4 && m_time_ok()) begin
          m_new = m_disp();
          m_lc  = (k == 11);
          m_la  = (k == 12);
          m_go_idle();
        end else begin
          m_mode = 2;
        end
      end
    end else if (os && m_mode != 0) begin
      m_secs++;
      if (m_secs >= TMO) m_go_idle();
    end
  endtask

  function automatic logic [35:0] model_vec();
    return {m_disp(), m_new, m_lc, m_la, (m_mode == 1), (m_mode == 2)};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
            lif.new_current_time_ms_hr, lif.new_current_time_ls_hr,
            lif.new_current_time_ms_min, lif.new_current_time_ls_min,
            lif.load_new_c, lif.load_new_a, entry_active, entry_error};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (key|new|lc la act err)", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge, sample 1ns later.
  task automatic run_cycle(input logic kv, input logic [3:0] kc, input logic os, input string name);
    @(negedge clk);
    key_valid  = kv;
    key_code   = kc;
    one_second = os;
    @(posedge clk);
    m_step(kv, kc, os);
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        os;
    logic [15:0] exp_key;
    logic [15:0] exp_new;
    logic        exp_lc, exp_la, exp_act, exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic kv, input logic [3:0] kc, input logic os,
                     input logic [15:0] k, input logic [15:0] n,
                     input logic lc, input logic la, input logic act, input logic err);
    vec_t v;
    v.kv = kv; v.kc = kc; v.os = os; v.exp_key = k; v.exp_new = n;
    v.exp_lc = lc; v.exp_la = la; v.exp_act = act; v.exp_err = err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] nv;
    reset = 1'b1; one_second = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 36'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table fill
    add(1, 4'd1, 0, 16'h0001, 16'h0000, 0, 0, 1, 0);
    add(1, 4'd2, 0, 16'h0012, 16'h0000, 0, 0, 1, 0);
    add(1, 4'd3, 0, 16'h0123, 16'h0000, 0, 0, 1, 0);
    add(1, 4'd4, 0, 16'h1234, 16'h0000, 0, 0, 1, 0);
    add(1, 4'hB, 0, 16'h0000, 16'h1234, 1, 0, 0, 0);
    add(0, 4'h0, 0, 16'h0000, 16'h1234, 0, 0, 0, 0);
    add(1, 4'd2, 0, 16'h0002, 16'h1234, 0, 0, 1, 0);
    add(1, 4'd3, 0, 16'h0023, 16'h1234, 0, 0, 1, 0);
    add(1, 4'd5, 0, 16'h0235, 16'h1234, 0, 0, 1, 0);
    add(1, 4'd9, 0, 16'h2359, 16'h1234, 0, 0, 1, 0);
    add(1, 4'hC, 0, 16'h0000, 16'h2359, 0, 1, 0, 0);
    add(1, 4'd1, 0, 16'h0001, 16'h2359, 0, 0, 1, 0);
    add(1, 4'd2, 0, 16'h0012, 16'h2359, 0, 0, 1, 0);
    add(1, 4'd3, 0, 16'h0123, 16'h2359, 0, 0, 1, 0);
    add(1, 4'd4, 0, 16'h1234, 16'h2359, 0, 0, 1, 0);
    add(1, 4'd5, 0, 16'h2345, 16'h2359, 0, 0, 1, 0);
    add(1, 4'hB, 0, 16'h0000, 16'h2345, 1, 0, 0, 0);
    add(1, 4'd2, 0, 16'h0002, 16'h2345, 0, 0, 1, 0);
    add(1, 4'd4, 0, 16'h0024, 16'h2345, 0, 0, 1, 0);
    add(1, 4'd0, 0, 16'h0240, 16'h2345, 0, 0, 1, 0);
    add(1, 4'd0, 0, 16'h2400, 16'h2345, 0, 0, 1, 0);
`ifdef TIME_ENTRY_RANGE_CHECK_EN
    nv = 16'h2345;
    add(1, 4'hB, 0, 16'h2400, nv, 0, 0, 0, 1);
`else
    nv = 16'h2400;
    add(1, 4'hB, 0, 16'h0000, nv, 1, 0, 0, 0);
`endif
    add(1, 4'hA, 0, 16'h0000, nv, 0, 0, 0, 0);
    add(1, 4'd1, 0, 16'h0001, nv, 0, 0, 1, 0);
    add(1, 4'd2, 0, 16'h0012, nv, 0, 0, 1, 0);
    add(1, 4'hB, 0, 16'h0012, nv, 0, 0, 0, 1);
    add(1, 4'd1, 0, 16'h0012, nv, 0, 0, 0, 1);
    for (int t = 1; t < TMO; t++) add(0, 4'h0, 1, 16'h0012, nv, 0, 0, 0, 1);
    add(0, 4'h0, 1, 16'h0000, nv, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      run_cycle(vecs[i].kv, vecs[i].kc, vecs[i].os, $sformatf("model_vec%0d", i));
      check($sformatf("table_vec%0d", i), dut_vec(),
            {vecs[i].exp_key, vecs[i].exp_new, vecs[i].exp_lc, vecs[i].exp_la,
             vecs[i].exp_act, vecs[i].exp_err});
    end

    // Key coinciding with the final tick suppresses the timeout and restarts the count
    run_cycle(1, 4'd5, 0, "coinc_key5");
    for (int t = 1; t < TMO; t++) run_cycle(0, 4'h0, 1, "coinc_tick");
    run_cycle(1, 4'd7, 1, "coinc_key7");
    check("coinc_no_timeout", dut_vec(), {16'h0057, nv, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int t = 1; t < TMO; t++) run_cycle(0, 4'h0, 1, "coinc_tick2");
    check("coinc_still_entry", dut_vec(), {16'h0057, nv, 1'b0, 1'b0, 1'b1, 1'b0});
    run_cycle(0, 4'h0, 1, "coinc_timeout");
    check("coinc_timeout_idle", dut_vec(), {16'h0000, nv, 1'b0, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset mid-entry
    run_cycle(1, 4'd1, 0, "rst_key1");
    run_cycle(1, 4'd2, 0, "rst_key2");
    run_cycle(1, 4'd3, 0, "rst_key3");
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", dut_vec(), 36'h0);
    m_reset();
    @(posedge clk);
    #1;
    check("reset_held", dut_vec(), 36'h0);
    @(negedge clk);
    reset = 1'b0;
    run_cycle(1, 4'hB, 0, "post_reset_load");
    check("post_reset_load_error", dut_vec(), {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
    run_cycle(1, 4'hA, 0, "post_reset_clear");

    // Random phases with varying key density so commits, errors and timeouts all occur
    for (int ph = 0; ph < 3; ph++) begin
      int kv_pct;
      kv_pct = (ph == 0) ? 50 : (ph == 1) ? 8 : 85;
      for (int c = 0; c < 400; c++) begin
        logic       kv, os;
        logic [3:0] kc;
        kv = ($urandom_range(0, 99) < kv_pct);
        os = ($urandom_range(0, 99) < 35);
        kc = ($urandom_range(0, 99) < 75) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        run_cycle(kv, kc, os, $sformatf("rand_p%0d_c%0d", ph, c));
        if (lif.load_new_c && lif.load_new_a) begin
          n_fail++;
          $display("FAIL strobe_exclusive: load_new_c=%b load_new_a=%b required not both 1",
                   lif.load_new_c, lif.load_new_a);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_entry_keypad.md
# time_entry_keypad

Keypad-entry front end for the alarm clock. It collects BCD digit keystrokes into a 4-digit HH:MM shift buffer and range-checks the entry. It then drives the parallel `new_*` digit bus plus a one-cycle `load_new_c` (clock time) or `load_new_a` (alarm time) strobe into the time counter / alarm register. It is the writer side of the counter's load interface.

## Interface
Parameters:
- TIMEOUT_SEC, 10: `one_second` ticks with no key before a partial entry is abandoned; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- one_second  in  1  one-cycle tick, once per second
- key_valid  in  1  one-cycle strobe; key_code is sampled only when high
- key_code  in  4  key codes:
  - 0–9: digit
  - 4'hA: CLEAR
  - 4'hB: LOAD_TIME
  - 4'hC: LOAD_ALARM
  - 4'hD–4'hF: ignored
- key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  out  4 each  live buffer, for display
- new_current_time_ms_hr, new_current_time_ls_hr, new_current_time_ms_min, new_current_time_ls_min  out  4 each  committed time
- load_new_c  out  1  one-cycle load strobe to the time counter
- load_new_a  out  1  one-cycle load strobe to the alarm register
- entry_active  out  1  high in ENTRY
- entry_error  out  1  high in ERROR

## Operation
- States: IDLE, ENTRY, ERROR.
- Digit accept: the buffer shifts left and the new digit enters at ls_min:
  - ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=digit.
  - digit_cnt (3 bit) increments and saturates at 4. Extra digits keep shifting, so the last four are retained.
- IDLE:
  - digit → accept, go to ENTRY.
  - LOAD_TIME / LOAD_ALARM → ERROR.
  - CLEAR / ignored codes → no change.
- ENTRY:
  - digit → accept.
  - CLEAR → buffer=0, digit_cnt=0, go to IDLE.
  - LOAD_TIME / LOAD_ALARM with digit_cnt==4 and the buffer valid:
    - copy the buffer to new_*;
    - pulse load_new_c (LOAD_TIME) or load_new_a (LOAD_ALARM);
    - clear buffer and digit_cnt, go to IDLE.
  - LOAD_TIME / LOAD_ALARM otherwise → ERROR; buffer retained for display.
  - Timeout → buffer=0, digit_cnt=0, go to IDLE.
- ERROR:
  - CLEAR or timeout → buffer=0, digit_cnt=0, go to IDLE.
  - All other keys ignored.
- Buffer valid when all of the following hold:
  - ms_hr≤2;
  - ls_hr≤9 when ms_hr<2, ls_hr≤3 when ms_hr==2;
  - ms_min≤5;
  - ls_min≤9.
- Timeout counter (4 bit):
  - cleared on every key_valid and on entry to IDLE;
  - increments on one_second while in ENTRY or ERROR;
  - reaching TIMEOUT_SEC fires the timeout.
- new_* hold their value between loads and change only on a successful commit.

## Timing
- Reset values: all buffer and new_* digits 4'd0; load_new_c, load_new_a, entry_active, entry_error all 0; state IDLE; digit_cnt 0; timer 0.
- Reset is asynchronous and aborts any entry mid-operation. No load strobe is issued during or after reset.
- Latency: key_valid sampled at edge N → buffer/state updated after N. A commit drives new_* and the strobe after N; the strobe is high for exactly one cycle, N→N+1.
- new_* are stable in the cycle the strobe is high; the consumer samples both on the same edge.
- key_valid and one_second in the same cycle: the key is processed and the timer is cleared; no timeout fires that cycle.
- Back-to-back keys on consecutive cycles are fully supported; throughput is one key per cycle.
- load_new_c and load_new_a are never high simultaneously.
- All outputs are registered.

## Configuration
- TIME_ENTRY_RANGE_CHECK_EN defined: the range check above applies; an out-of-range entry goes to ERROR.
- Not defined: the range check is removed. Any 4-digit entry commits, and the downstream counter sees raw digits. The digit_cnt==4 requirement remains in both builds.

## Structure
- Package time_entry_pkg holds:
  - key code localparams: KEY_CLEAR, KEY_LOAD_TIME, KEY_LOAD_ALARM;
  - state encoding for IDLE/ENTRY/ERROR;
  - bcd_time_valid function (four 4-bit digits → 1 bit).
- One sub-module, entry_timeout_timer: clear, enable, tick inputs; TIMEOUT_SEC parameter; one-cycle expired output.

## Test plan
- Keys 1,2,3,4, LOAD_TIME → load_new_c one cycle after LOAD; new_* = 1,2,3,4; load_new_a stays 0; state IDLE; buffer 0.
- Keys 2,3,5,9, LOAD_ALARM → load_new_a pulse; new_* = 2,3,5,9. Then keys 1,2,3,4,5, LOAD_TIME → new_* = 2,3,4,5.
- Keys 2,4,0,0, LOAD_TIME with the macro defined → entry_error=1, no strobe, new_* unchanged; CLEAR → IDLE, error=0. Same keys without the macro → load_new_c with new_* = 2,4,0,0.
- Keys 1,2, LOAD_TIME → ERROR, buffer displays 0,0,1,2. Key 1 then 10 one_second ticks → IDLE, buffer 0, no strobe.
- key_valid(digit 7) and one_second coincide on the 10th tick → no timeout; timer cleared; digit accepted.
- Assert reset while in ENTRY after 3 digits → all outputs 0 immediately; the following LOAD_TIME → ERROR.
